// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between an instruction-fetch port and a data port.
// Data accesses win by default, fetch starvation is bounded, and a stuck access is aborted after a timeout.
module mem_port_arbiter #(
  parameter int TIMEOUT    = 15,
  parameter int STARVE_MAX = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [3:0]  dm_wstrb,
  output logic [31:0] dm_rdata,
  output logic        dm_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_IF = 2'd1,
    GNT_DM = 2'd2,
    RESP   = 2'd3
  } state_e;

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TMO_ONE    = TW'(1);
  localparam logic [SW-1:0] STARVE_SAT = SW'(STARVE_MAX);
  localparam logic [SW-1:0] STARVE_ONE = SW'(1);

  state_e          state_q,     state_d;
  logic [SW-1:0]   starve_q,    starve_d;
  logic [TW-1:0]   tmo_q,       tmo_d;
  logic            mem_req_q,   mem_req_d;
  logic            mem_we_q,    mem_we_d;
  logic [31:0]     mem_addr_q,  mem_addr_d;
  logic [31:0]     mem_wdata_q, mem_wdata_d;
  logic [3:0]      mem_wstrb_q, mem_wstrb_d;
  logic [31:0]     if_rdata_q,  if_rdata_d;
  logic [31:0]     dm_rdata_q,  dm_rdata_d;
  logic            if_ready_q,  if_ready_d;
  logic            dm_ready_q,  dm_ready_d;
  logic            err_q,       err_d;

  logic            fetch_forced;
  logic            grant_dm;
  logic            grant_if;

  // Fetch overrides the data port once the data port has had its run of grants.
  assign fetch_forced = if_req && (starve_q == STARVE_SAT);
  assign grant_dm     = dm_req && !fetch_forced;
  assign grant_if     = if_req && !grant_dm;

  // NOTE: every signal assigned in this block gets its default first, so no
  // path through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    tmo_d       = tmo_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ready_d  = 1'b0;
    dm_ready_d  = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (grant_dm) begin
          state_d     = GNT_DM;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          mem_wstrb_d = dm_wstrb;
          if (!if_req) begin
            starve_d = '0;
          end else if (starve_q != STARVE_SAT) begin
            starve_d = starve_q + STARVE_ONE;
          end
        end else if (grant_if) begin
          state_d     = GNT_IF;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          mem_wstrb_d = '0;
          starve_d    = '0;
        end
      end

      GNT_IF, GNT_DM: begin
        if (mem_ack) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          tmo_d     = '0;
          if (state_q == GNT_IF) begin
            if_rdata_d = mem_rdata;
            if_ready_d = 1'b1;
          end else begin
            // A store completes without disturbing the last load result.
            if (!mem_we_q) begin
              dm_rdata_d = mem_rdata;
            end
            dm_ready_d = 1'b1;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          tmo_d     = '0;
          err_d     = 1'b1;
          if (state_q == GNT_IF) begin
            if_rdata_d = '0;
            if_ready_d = 1'b1;
          end else begin
            dm_rdata_d = '0;
            dm_ready_d = 1'b1;
          end
        end else begin
          tmo_d = tmo_q + TMO_ONE;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  // NOTE: the data-path registers are reset as well, since they drive visible
  // outputs that must read zero while the arbiter is held in reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      tmo_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      tmo_q       <= tmo_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ready_q  <= if_ready_d;
      dm_ready_q  <= dm_ready_d;
      err_q       <= err_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_ready  = if_ready_q;
  assign dm_ready  = dm_ready_q;
  assign err       = err_q;

  // Stalls follow the request combinationally so the pipeline frees up in the ready cycle.
  assign stall_if  = if_req & ~if_ready_q;
  assign stall_mem = dm_req & ~dm_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a transaction model.
module tb_mem_port_arbiter;

  localparam int TIMEOUT    = 15;
  localparam int STARVE_MAX = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic [3:0]  dm_wstrb;
  logic [31:0] if_rdata, dm_rdata;
  logic        if_ready, dm_ready;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall_if, stall_mem, err;

  always #5 clk = ~clk;

  mem_port_arbiter #(.TIMEOUT(TIMEOUT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_wstrb(dm_wstrb), .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem), .err(err)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory responder ----------------
  int          mem_lat     = 1;
  int          mem_cnt     = 0;
  bit          mem_rand    = 1'b0;
  bit          spurious_en = 1'b0;
  logic [31:0] fixed_rdata = '0;

  initial begin
    int r;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req) begin
        mem_cnt++;
        mem_ack = (mem_cnt == mem_lat);
      end else begin
        mem_cnt = 0;
        mem_ack = spurious_en && ($urandom_range(0, 3) == 0);
        if (mem_rand) begin
          r = int'($urandom_range(0, 9));
          mem_lat = (r == 0) ? TIMEOUT : (r == 1) ? TIMEOUT + 1 : (r == 2) ? 100
                  : int'($urandom_range(1, 4));
        end
      end
      mem_rdata = mem_rand ? $urandom : fixed_rdata;
    end
  end

  // ---------------- transaction-level reference model ----------------
  int          m_busy;       // port with an access outstanding: 0 none, 1 fetch, 2 data
  int          m_done;       // port whose completion is being reported this cycle
  int          m_dm_streak;  // data grants in a row while a fetch was waiting
  logic        m_err, m_we;
  logic [31:0] m_addr, m_wdata, m_if_rdata, m_dm_rdata;
  logic [3:0]  m_wstrb;
  longint      cyc = 0, m_gnt_cyc = 0;
  logic [31:0] m_ord = '0;

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_dm_streak = 0;
    m_err = 1'b0; m_we = 1'b0;
    m_addr = '0; m_wdata = '0; m_wstrb = '0;
    m_if_rdata = '0; m_dm_rdata = '0;
  endtask

  task automatic model_step();
    bit take_dm;
    cyc++;
    m_err = 1'b0;
    if (m_done != 0) begin
      m_done = 0;
    end else if (m_busy != 0) begin
      if (mem_ack) begin
        if (m_busy == 1) m_if_rdata = mem_rdata;
        else if (!m_we)  m_dm_rdata = mem_rdata;
        m_done = m_busy;
        m_busy = 0;
      end else if (cyc - m_gnt_cyc == longint'(TIMEOUT)) begin
        if (m_busy == 1) m_if_rdata = '0;
        else             m_dm_rdata = '0;
        m_err  = 1'b1;
        m_done = m_busy;
        m_busy = 0;
      end
    end else if (dm_req || if_req) begin
      take_dm   = dm_req && !(if_req && m_dm_streak == STARVE_MAX);
      m_gnt_cyc = cyc;
      if (take_dm) begin
        m_busy = 2; m_we = dm_we; m_addr = dm_addr; m_wdata = dm_wdata; m_wstrb = dm_wstrb;
        m_dm_streak = !if_req ? 0 : (m_dm_streak < STARVE_MAX) ? m_dm_streak + 1 : STARVE_MAX;
        m_ord = {m_ord[27:0], 4'hD};
      end else begin
        m_busy = 1; m_we = 1'b0; m_addr = if_addr; m_wdata = '0; m_wstrb = '0;
        m_dm_streak = 0;
        m_ord = {m_ord[27:0], 4'h1};
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else      model_step();
    end
  end

  // ---------------- per-cycle comparison ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        check("mem_req",   32'(mem_req),   32'(m_busy != 0));
        check("if_ready",  32'(if_ready),  32'(m_done == 1));
        check("dm_ready",  32'(dm_ready),  32'(m_done == 2));
        check("err",       32'(err),       32'(m_err));
        check("if_rdata",  if_rdata,       m_if_rdata);
        check("dm_rdata",  dm_rdata,       m_dm_rdata);
        check("stall_if",  32'(stall_if),  32'(if_req & ~(m_done == 1)));
        check("stall_mem", 32'(stall_mem), 32'(dm_req & ~(m_done == 2)));
        if (!rst || m_busy != 0) begin
          check("mem_we",    32'(mem_we),    32'(m_we));
          check("mem_addr",  mem_addr,       m_addr);
          check("mem_wstrb", 32'(mem_wstrb), 32'(m_wstrb));
        end
        if (!rst || m_busy == 2) check("mem_wdata", mem_wdata, m_wdata);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  int          stall_cnt, pulses, ngr, req_cycles, err_cnt, g_cyc, r_cyc, ready_cnt;
  logic        prev_req, stable, err_at, got;
  logic [31:0] cap, ord;
  logic [31:0] g_addr [4];
  logic [31:0] g_wdata[4];
  logic        g_we   [4];
  logic [3:0]  g_wstrb[4];

  initial begin
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_wstrb = '0;
    #2 rst = 1'b0;
    cmp_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_req",  32'(mem_req), 32'd0);
    check("rst_mem_addr", mem_addr,     32'd0);
    check("rst_if_rdata", if_rdata,     32'd0);
    check("rst_dm_rdata", dm_rdata,     32'd0);
    check("rst_err",      32'(err),     32'd0);
    @(negedge clk);
    #1 rst = 1'b1;

    // Single fetch with a one-cycle memory.
    fixed_rdata = 32'h0050_0113; mem_lat = 1;
    @(posedge clk);
    #1;
    if_req = 1'b1; if_addr = 32'h10;
    stall_cnt = 0; pulses = 0; cap = '0;
    repeat (6) begin
      @(negedge clk);
      if (stall_if) stall_cnt++;
      if (if_ready) begin
        pulses++; cap = if_rdata;
        #1 if_req = 1'b0;
      end
    end
    check("s1_ready_pulses",  32'(pulses),    32'd1);
    check("s1_if_rdata",      cap,            32'h0050_0113);
    check("s1_stall_cycles",  32'(stall_cnt), 32'd2);
    check("s1_model_if_rdata", m_if_rdata,    32'h0050_0113);

    // Store and fetch raised together: data first with stable fields, then fetch.
    fixed_rdata = 32'hDEAD_BEEF; mem_lat = 3;
    @(negedge clk);
    #1;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h3FC; dm_wdata = 32'h8; dm_wstrb = 4'hF;
    if_req = 1'b1; if_addr = 32'h20;
    ngr = 0; stable = 1'b1; prev_req = 1'b0;
    for (int i = 0; i < 30 && (if_req || dm_req); i++) begin
      @(negedge clk);
      if (mem_req && !prev_req) begin
        if (ngr < 4) begin
          g_addr[ngr] = mem_addr; g_we[ngr] = mem_we;
          g_wdata[ngr] = mem_wdata; g_wstrb[ngr] = mem_wstrb;
        end
        ngr++;
      end else if (mem_req && ngr > 0 && ngr <= 4) begin
        if (mem_addr !== g_addr[ngr-1] || mem_we !== g_we[ngr-1] || mem_wstrb !== g_wstrb[ngr-1]
            || (g_we[ngr-1] && mem_wdata !== g_wdata[ngr-1])) stable = 1'b0;
      end
      prev_req = mem_req;
      if (dm_ready || if_ready) begin
        #1;
        if (dm_ready) dm_req = 1'b0;
        if (if_ready) if_req = 1'b0;
      end
    end
    check("s2_grants",      32'(ngr),        32'd2);
    check("s2_first_we",    32'(g_we[0]),    32'd1);
    check("s2_first_addr",  g_addr[0],       32'h3FC);
    check("s2_first_wdata", g_wdata[0],      32'h8);
    check("s2_first_wstrb", 32'(g_wstrb[0]), 32'hF);
    check("s2_second_addr", g_addr[1],       32'h20);
    check("s2_second_we",   32'(g_we[1]),    32'd0);
    check("s2_second_wstrb", 32'(g_wstrb[1]), 32'd0);
    check("s2_fields_stable", 32'(stable),   32'd1);
    check("s2_dm_rdata_kept", dm_rdata,      32'd0);
    check("s2_if_rdata",    if_rdata,        32'hDEAD_BEEF);

    // Both ports held continuously: bounded starvation pattern.
    fixed_rdata = 32'h1234_5678; mem_lat = 1;
    @(negedge clk);
    #1;
    m_ord = '0; ord = '0; ngr = 0; prev_req = 1'b0;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200;
    if_req = 1'b1; if_addr = 32'h100;
    for (int i = 0; i < 80 && ngr < 6; i++) begin
      @(negedge clk);
      if (mem_req && !prev_req) begin
        ord = {ord[27:0], (mem_addr == 32'h200) ? 4'hD : 4'h1};
        ngr++;
      end
      prev_req = mem_req;
    end
    #1;
    if_req = 1'b0; dm_req = 1'b0;
    check("s3_grant_order",  ord,   32'h00DD_1DD1);
    check("s3_model_order",  m_ord, 32'h00DD_1DD1);
    repeat (4) @(negedge clk);

    // Memory never acks: timeout aborts the data load.
    mem_lat = 1000;
    #1;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40;
    g_cyc = -1; r_cyc = -1; req_cycles = 0; err_cnt = 0; err_at = 1'b0; cap = 32'hFFFF_FFFF;
    for (int i = 0; i < 40 && dm_req; i++) begin
      @(negedge clk);
      if (mem_req) begin
        req_cycles++;
        if (g_cyc < 0) g_cyc = i;
      end
      if (err) err_cnt++;
      if (dm_ready) begin
        r_cyc = i; err_at = err; cap = dm_rdata;
        #1 dm_req = 1'b0;
      end
    end
    repeat (3) begin
      @(negedge clk);
      if (err) err_cnt++;
    end
    check("s4_ready_delay",  32'(r_cyc - g_cyc), 32'd15);
    check("s4_req_cycles",   32'(req_cycles),    32'd15);
    check("s4_err_with_rdy", 32'(err_at),        32'd1);
    check("s4_err_pulses",   32'(err_cnt),       32'd1);
    check("s4_dm_rdata",     cap,                32'd0);
    check("s4_model_rdata",  m_dm_rdata,         32'd0);

    // Reset in the middle of a data grant, then a clean access.
    fixed_rdata = 32'hCAFE_0001; mem_lat = 1000;
    @(negedge clk);
    #1;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h80;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (mem_req) got = 1'b1;
    end
    check("s5_granted", 32'(got), 32'd1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("s5_async_drop", 32'(mem_req), 32'd0);
    ready_cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (dm_ready || if_ready) ready_cnt++;
    end
    @(posedge clk);
    #2;
    mem_lat = 2;
    rst = 1'b1;
    #1;
    check("s5_no_early_grant", 32'(mem_req), 32'd0);
    got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge clk);
      if (dm_ready) begin
        got = 1'b1; cap = dm_rdata;
        #1 dm_req = 1'b0;
      end
    end
    check("s5_no_ready_in_rst", 32'(ready_cnt), 32'd0);
    check("s5_completes",       32'(got),       32'd1);
    check("s5_dm_rdata",        cap,            32'hCAFE_0001);
    repeat (3) @(negedge clk);

    // Randomized traffic against the model.
    mem_rand = 1'b1; spurious_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      #1;
      if (if_ready || !if_req) begin
        if_req  = ($urandom_range(0, 3) != 0);
        if_addr = $urandom & 32'hFFFF_FFFC;
      end else if ($urandom_range(0, 63) == 0) begin
        if_req = 1'b0;
      end
      if (dm_ready || !dm_req) begin
        dm_req   = ($urandom_range(0, 2) != 0);
        dm_we    = 1'(($urandom_range(0, 1)));
        dm_addr  = $urandom & 32'hFFFF_FFFC;
        dm_wdata = $urandom;
        dm_wstrb = 4'($urandom_range(0, 15));
      end else if ($urandom_range(0, 63) == 0) begin
        dm_req = 1'b0;
      end
      if ($urandom_range(0, 399) == 0) begin
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
      end
    end

    if_req = 1'b0; dm_req = 1'b0;
    repeat (20) @(negedge clk);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
